// File: rtl/gpu_bg_block_mem.sv
// Background block sequencer: writes the masked pixels of a 16-pixel block and
// optionally reads the background block back for blending, one 32-bit beat at a time.
module gpu_bg_block_mem (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_blockOp,
  input  logic [1:0]   i_blockStep,
  input  logic         i_blendActive,
  input  logic [14:0]  i_loadAdr,
  input  logic [14:0]  i_saveAdr,
  input  logic [255:0] i_saveBlock,
  input  logic [15:0]  i_saveMask,
  output logic         o_importStrobe,
  output logic [255:0] o_importBlock,
  output logic         o_resetMask,
  output logic         o_busy,
  output logic         o_memReq,
  output logic         o_memWrite,
  output logic [17:0]  o_memAdr,
  output logic [31:0]  o_memWData,
  output logic [3:0]   o_memBE,
  input  logic         i_memAck,
  input  logic         i_memRValid,
  input  logic [31:0]  i_memRData
);
  typedef enum logic [1:0] {IDLE, SAVE, LOAD, DONE} state_t;

  state_t         state_q;
  logic           op_q;
  logic           blend_q;
  logic           issued_q;
  logic [14:0]    load_adr_q;
  logic [14:0]    save_adr_q;
  logic [255:0]   save_blk_q;
  logic [255:0]   blk_q;
  logic [15:0]    mask_q;
  logic [2:0]     beat_q;
  logic [2:0]     rcnt_q;
  logic           start;
  logic [3:0]     first_beat;
  logic [3:0]     nxt_beat;
  logic [1:0]     pair;

  // Lowest beat index >= from whose two mask bits are not both clear; bit 3 set = none left.
  function automatic logic [3:0] next_beat(input logic [15:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = 7; i >= 0; i--) begin
      if (i >= int'(from) && (m[2*i +: 2] != 2'b00)) r = {1'b0, 3'(i)};
    end
    return r;
  endfunction

  assign start      = i_blockOp & ~op_q & (state_q == IDLE) & ~i_rst;
  assign o_busy     = ~i_rst & ((state_q != IDLE) | start);
  assign first_beat = next_beat(i_saveMask, 4'd0);
  assign nxt_beat   = next_beat(mask_q, {1'b0, beat_q} + 4'd1);
  assign pair       = mask_q[{beat_q, 1'b0} +: 2];

  assign o_resetMask    = (state_q == DONE);
  assign o_importStrobe = (state_q == DONE) & blend_q;
  assign o_importBlock  = blk_q;

  always_comb begin
    o_memReq   = 1'b0;
    o_memWrite = 1'b0;
    o_memAdr   = 18'd0;
    o_memWData = 32'd0;
    o_memBE    = 4'd0;
    if (state_q == SAVE) begin
      o_memReq   = 1'b1;
      o_memWrite = 1'b1;
      o_memAdr   = {save_adr_q, beat_q};
      o_memWData = save_blk_q[{beat_q, 5'b0} +: 32];
      o_memBE    = {pair[1], pair[1], pair[0], pair[0]};
    end else if (state_q == LOAD && !issued_q) begin
      o_memReq = 1'b1;
      o_memAdr = {load_adr_q, beat_q};
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      blend_q    <= 1'b0;
      issued_q   <= 1'b0;
      load_adr_q <= 15'd0;
      save_adr_q <= 15'd0;
      save_blk_q <= 256'd0;
      blk_q      <= 256'd0;
      mask_q     <= 16'd0;
      beat_q     <= 3'd0;
      rcnt_q     <= 3'd0;
    end else begin
      op_q <= i_blockOp;
      case (state_q)
        IDLE: if (start) begin
          blend_q    <= i_blendActive;
          load_adr_q <= i_loadAdr;
          save_adr_q <= i_saveAdr;
          save_blk_q <= i_saveBlock;
          mask_q     <= i_saveMask;
          issued_q   <= 1'b0;
          rcnt_q     <= 3'd0;
          beat_q     <= 3'd0;
          // Step 01 is the first block of a span: nothing has been drawn to save yet.
          if (i_blockStep != 2'b01 && i_saveMask != 16'd0) begin
            state_q <= SAVE;
            beat_q  <= first_beat[2:0];
          end else if (i_blendActive) begin
            state_q <= LOAD;
          end else begin
            state_q <= DONE;
          end
        end
        SAVE: if (i_memAck) begin
          if (!nxt_beat[3]) begin
            beat_q <= nxt_beat[2:0];
          end else if (blend_q) begin
            state_q <= LOAD;
            beat_q  <= 3'd0;
          end else begin
            state_q <= DONE;
          end
        end
        LOAD: begin
          if (i_memAck && !issued_q) begin
            if (beat_q == 3'd7) issued_q <= 1'b1;
            else                beat_q   <= beat_q + 3'd1;
          end
          if (i_memRValid) begin
            blk_q[{rcnt_q, 5'b0} +: 32] <= i_memRData;
            if (rcnt_q == 3'd7) state_q <= DONE;
            else                rcnt_q  <= rcnt_q + 3'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_bg_block_mem.sv
// Directed bench for gpu_bg_block_mem with a memory responder (stallable ack, fixed read latency).
module tb_gpu_bg_block_mem;
  logic         clk = 1'b0;
  logic         i_rst, i_blockOp, i_blendActive;
  logic [1:0]   i_blockStep;
  logic [14:0]  i_loadAdr, i_saveAdr;
  logic [255:0] i_saveBlock;
  logic [15:0]  i_saveMask;
  logic         o_importStrobe, o_resetMask, o_busy;
  logic [255:0] o_importBlock;
  logic         o_memReq, o_memWrite;
  logic [17:0]  o_memAdr;
  logic [31:0]  o_memWData;
  logic [3:0]   o_memBE;
  logic         i_memAck, i_memRValid;
  logic [31:0]  i_memRData;

  gpu_bg_block_mem dut (
    .clk(clk), .i_rst(i_rst), .i_blockOp(i_blockOp), .i_blockStep(i_blockStep),
    .i_blendActive(i_blendActive), .i_loadAdr(i_loadAdr), .i_saveAdr(i_saveAdr),
    .i_saveBlock(i_saveBlock), .i_saveMask(i_saveMask), .o_importStrobe(o_importStrobe),
    .o_importBlock(o_importBlock), .o_resetMask(o_resetMask), .o_busy(o_busy),
    .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memAdr(o_memAdr),
    .o_memWData(o_memWData), .o_memBE(o_memBE), .i_memAck(i_memAck),
    .i_memRValid(i_memRValid), .i_memRData(i_memRData)
  );

  always #5 clk = ~clk;

  localparam int LAT = 3;
  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int stall = 0;
  logic [17:0] wr_adr[$];
  logic [3:0]  wr_be[$];
  logic [31:0] wr_dat[$];
  logic [17:0] rd_adr[$];
  int          rd_due[$];
  logic [17:0] rd_qadr[$];
  int          wait_cnt = 0, unstable = 0, stall_cycles = 0;
  logic [17:0] h_adr;
  logic [31:0] h_dat;
  logic [3:0]  h_be;
  logic        h_we;

  logic [255:0] sblk, exp_blk, got_blk, prev_blk;
  int   busy_cnt, n_cyc, strobe_cnt, rm_cnt;
  logic timed_out, first_req, post_busy, post_req, busy_start;
  logic [17:0] first_adr;

  always @(posedge clk) cyc++;

  // Memory responder: acks after `stall` waiting cycles, returns read data LAT edges after the ack.
  always @(negedge clk) begin
    i_memRValid = 1'b0;
    i_memRData  = 32'd0;
    if (rd_due.size() > 0 && rd_due[0] == cyc + 1) begin
      i_memRValid = 1'b1;
      i_memRData  = {14'h1555, rd_qadr[0]};
      void'(rd_due.pop_front());
      void'(rd_qadr.pop_front());
    end
    if (o_memReq) begin
      if (wait_cnt == 0) begin
        h_adr = o_memAdr; h_dat = o_memWData; h_be = o_memBE; h_we = o_memWrite;
      end else if (h_adr !== o_memAdr || h_dat !== o_memWData || h_be !== o_memBE || h_we !== o_memWrite) begin
        unstable++;
      end
      if (wait_cnt == stall) begin
        i_memAck = 1'b1;
        wait_cnt = 0;
        if (o_memWrite) begin
          wr_adr.push_back(o_memAdr); wr_be.push_back(o_memBE); wr_dat.push_back(o_memWData);
        end else begin
          rd_adr.push_back(o_memAdr); rd_due.push_back(cyc + 1 + LAT); rd_qadr.push_back(o_memAdr);
        end
      end else begin
        i_memAck = 1'b0;
        wait_cnt++;
        stall_cycles++;
      end
    end else begin
      i_memAck = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic start_cmd(input logic [1:0] step, input logic blend, input logic [14:0] ladr,
                           input logic [14:0] sadr, input logic [15:0] mask);
    @(negedge clk);
    wr_adr.delete(); wr_be.delete(); wr_dat.delete(); rd_adr.delete();
    unstable = 0; stall_cycles = 0;
    i_blockStep = step; i_blendActive = blend; i_loadAdr = ladr; i_saveAdr = sadr;
    i_saveMask = mask; i_saveBlock = sblk; i_blockOp = 1'b1;
    #1 busy_start = o_busy;
  endtask

  task automatic wait_done(input bit hold);
    timed_out = 1'b1; busy_cnt = 0; n_cyc = 0; strobe_cnt = 0; rm_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) begin
        first_req = o_memReq; first_adr = o_memAdr;
        if (!hold) i_blockOp = 1'b0;
        i_saveBlock = ~i_saveBlock; i_saveMask = ~i_saveMask; i_loadAdr = ~i_loadAdr;
        i_saveAdr = ~i_saveAdr; i_blendActive = ~i_blendActive; i_blockStep = ~i_blockStep;
      end
      n_cyc++;
      if (o_busy) busy_cnt++;
      if (o_importStrobe) begin strobe_cnt++; got_blk = o_importBlock; end
      if (o_resetMask) begin rm_cnt++; timed_out = 1'b0; break; end
    end
    @(negedge clk);
    post_busy = o_busy; post_req = o_memReq;
  endtask

  task automatic build_exp(input logic [14:0] ladr);
    for (int n = 0; n < 8; n++) exp_blk[32*n +: 32] = {14'h1555, ladr, 3'(n)};
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_blockOp = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({o_memReq, o_memWrite, o_memBE, o_memAdr, o_memWData} !== '0) begin
      miscompares++; $display("FAIL rst_mem: req=%b we=%b be=%h adr=%h wd=%h want all 0", o_memReq, o_memWrite, o_memBE, o_memAdr, o_memWData);
    end
    vectors++;
    if ({o_importStrobe, o_resetMask, o_busy, o_importBlock} !== '0) begin
      miscompares++; $display("FAIL rst_status: strobe=%b rm=%b busy=%b blk=%h want 0", o_importStrobe, o_resetMask, o_busy, o_importBlock);
    end
    i_blockOp = 1'b0;
    @(negedge clk) i_rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || o_memReq !== 1'b0) begin
      miscompares++; $display("FAIL rst_release: busy=%b req=%b want 0 0", o_busy, o_memReq);
    end
  endtask

  task automatic test_load_only;
    stall = 0;
    start_cmd(2'b01, 1'b1, 15'h0123, 15'h0077, 16'hFFFF);
    wait_done(1'b0);
    build_exp(15'h0123);
    vectors++;
    if (busy_start !== 1'b1) begin miscompares++; $display("FAIL t1_busy_start: got %b want 1", busy_start); end
    vectors++;
    if (first_req !== 1'b1 || first_adr !== 18'h00918) begin
      miscompares++; $display("FAIL t1_first_beat: req=%b adr=%h want 1 00918", first_req, first_adr);
    end
    vectors++;
    if (timed_out || wr_adr.size() != 0 || rd_adr.size() != 8) begin
      miscompares++; $display("FAIL t1_counts: timeout=%b writes=%0d reads=%0d want 0 0 8", timed_out, wr_adr.size(), rd_adr.size());
    end
    for (int n = 0; n < 8; n++) begin
      vectors++;
      if (rd_adr.size() <= n || rd_adr[n] !== 18'h00918 + 18'(n)) begin
        miscompares++; $display("FAIL t1_read_adr%0d: got %h want %h", n, rd_adr.size() > n ? rd_adr[n] : 18'h0, 18'h00918 + 18'(n));
      end
    end
    vectors++;
    if (strobe_cnt != 1 || rm_cnt != 1) begin miscompares++; $display("FAIL t1_strobes: import=%0d rm=%0d want 1 1", strobe_cnt, rm_cnt); end
    vectors++;
    if (got_blk !== exp_blk) begin miscompares++; $display("FAIL t1_block: got %h want %h", got_blk, exp_blk); end
    vectors++;
    if (busy_cnt != 12 || n_cyc != 12 || post_busy !== 1'b0) begin
      miscompares++; $display("FAIL t1_busy: busy=%0d cycles=%0d after=%b want 12 12 0", busy_cnt, n_cyc, post_busy);
    end
    prev_blk = exp_blk;
  endtask

  task automatic test_single_write;
    stall = 0;
    start_cmd(2'b10, 1'b0, 15'h0055, 15'h1ABC, 16'h0003);
    wait_done(1'b0);
    vectors++;
    if (timed_out || wr_adr.size() != 1 || rd_adr.size() != 0) begin
      miscompares++; $display("FAIL t2_counts: timeout=%b writes=%0d reads=%0d want 0 1 0", timed_out, wr_adr.size(), rd_adr.size());
    end
    vectors++;
    if (wr_adr.size() < 1 || wr_adr[0] !== 18'h0D5E0 || wr_be[0] !== 4'hF || wr_dat[0] !== 32'h10203040) begin
      miscompares++; $display("FAIL t2_beat: adr=%h be=%h dat=%h want 0d5e0 f 10203040", wr_adr.size() > 0 ? wr_adr[0] : 18'h0, wr_be.size() > 0 ? wr_be[0] : 4'h0, wr_dat.size() > 0 ? wr_dat[0] : 32'h0);
    end
    vectors++;
    if (rm_cnt != 1 || strobe_cnt != 0) begin miscompares++; $display("FAIL t2_strobes: rm=%0d import=%0d want 1 0", rm_cnt, strobe_cnt); end
    vectors++;
    if (o_importBlock !== prev_blk) begin miscompares++; $display("FAIL t2_block_hold: got %h want %h", o_importBlock, prev_blk); end
  endtask

  task automatic test_stall_write;
    stall = 4;
    start_cmd(2'b10, 1'b1, 15'h7FFF, 15'h0005, 16'h8001);
    wait_done(1'b0);
    build_exp(15'h7FFF);
    vectors++;
    if (timed_out || wr_adr.size() != 2 || rd_adr.size() != 8) begin
      miscompares++; $display("FAIL t3_counts: timeout=%b writes=%0d reads=%0d want 0 2 8", timed_out, wr_adr.size(), rd_adr.size());
    end
    vectors++;
    if (wr_adr.size() < 1 || wr_adr[0] !== 18'h00028 || wr_be[0] !== 4'h3 || wr_dat[0] !== 32'h10203040) begin
      miscompares++; $display("FAIL t3_beat0: adr=%h be=%h want 00028 3", wr_adr.size() > 0 ? wr_adr[0] : 18'h0, wr_be.size() > 0 ? wr_be[0] : 4'h0);
    end
    vectors++;
    if (wr_adr.size() < 2 || wr_adr[1] !== 18'h0002F || wr_be[1] !== 4'hC || wr_dat[1] !== 32'h81018200) begin
      miscompares++; $display("FAIL t3_beat7: adr=%h be=%h want 0002f c", wr_adr.size() > 1 ? wr_adr[1] : 18'h0, wr_be.size() > 1 ? wr_be[1] : 4'h0);
    end
    vectors++;
    if (unstable != 0 || stall_cycles != 40) begin
      miscompares++; $display("FAIL t3_stall_hold: unstable=%0d stalled=%0d want 0 40", unstable, stall_cycles);
    end
    vectors++;
    if (rd_adr.size() != 8 || rd_adr[0] !== 18'h3FFF8 || rd_adr[7] !== 18'h3FFFF) begin
      miscompares++; $display("FAIL t3_reads: n=%0d want 8 at 3fff8..3ffff", rd_adr.size());
    end
    vectors++;
    if (strobe_cnt != 1 || got_blk !== exp_blk) begin
      miscompares++; $display("FAIL t3_block: strobes=%0d got %h want %h", strobe_cnt, got_blk, exp_blk);
    end
    stall = 0;
  endtask

  task automatic test_held_op;
    int extra_rm, extra_req;
    stall = 0;
    start_cmd(2'b10, 1'b1, 15'h0333, 15'h0011, 16'h0000);
    wait_done(1'b1);
    build_exp(15'h0333);
    vectors++;
    if (timed_out || wr_adr.size() != 0 || rd_adr.size() != 8) begin
      miscompares++; $display("FAIL t4_counts: timeout=%b writes=%0d reads=%0d want 0 0 8", timed_out, wr_adr.size(), rd_adr.size());
    end
    vectors++;
    if (strobe_cnt != 1 || got_blk !== exp_blk) begin
      miscompares++; $display("FAIL t4_block: strobes=%0d got %h want %h", strobe_cnt, got_blk, exp_blk);
    end
    extra_rm = 0; extra_req = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (o_resetMask) extra_rm++;
      if (o_memReq || o_busy) extra_req++;
    end
    i_blockOp = 1'b0;
    vectors++;
    if (extra_rm != 0 || extra_req != 0) begin
      miscompares++; $display("FAIL t4_single_cmd: extra_rm=%0d active=%0d want 0 0", extra_rm, extra_req);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    int rv_cnt, act;
    stall = 0;
    start_cmd(2'b01, 1'b1, 15'h0200, 15'h0000, 16'h0000);
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0) i_blockOp = 1'b0;
      if (rd_adr.size() >= 3) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL t5_reach_ack3: reads=%0d want 3", rd_adr.size()); end
    @(posedge clk);
    #1 i_rst = 1'b1;
    #1;
    vectors++;
    if ({o_memReq, o_memWrite, o_memBE, o_memAdr, o_memWData, o_importStrobe, o_resetMask, o_busy, o_importBlock} !== '0) begin
      miscompares++; $display("FAIL t5_rst_outputs: req=%b busy=%b adr=%h blk=%h want all 0", o_memReq, o_busy, o_memAdr, o_importBlock);
    end
    @(negedge clk);
    @(negedge clk) i_rst = 1'b0;
    rv_cnt = 0; act = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_memRValid) rv_cnt++;
      if (o_busy || o_memReq || o_importStrobe || o_resetMask) act++;
    end
    vectors++;
    if (rv_cnt < 1 || act != 0) begin
      miscompares++; $display("FAIL t5_stale_rvalid: pulses=%0d activity=%0d want >=1 0", rv_cnt, act);
    end
    start_cmd(2'b01, 1'b1, 15'h0040, 15'h0000, 16'h0000);
    wait_done(1'b0);
    build_exp(15'h0040);
    vectors++;
    if (timed_out || rd_adr.size() != 8 || rd_adr[0] !== 18'h00200) begin
      miscompares++; $display("FAIL t5_restart_reads: timeout=%b n=%0d want 0 8 from 00200", timed_out, rd_adr.size());
    end
    vectors++;
    if (strobe_cnt != 1 || got_blk !== exp_blk) begin
      miscompares++; $display("FAIL t5_restart_block: strobes=%0d got %h want %h", strobe_cnt, got_blk, exp_blk);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_blockOp = 1'b0; i_blockStep = 2'b00; i_blendActive = 1'b0;
    i_loadAdr = '0; i_saveAdr = '0; i_saveBlock = '0; i_saveMask = '0;
    i_memAck = 1'b0; i_memRValid = 1'b0; i_memRData = '0;
    for (int k = 0; k < 8; k++) sblk[32*k +: 32] = 32'h10203040 * (k + 1);
    prev_blk = '0;
    test_reset();
    test_load_only();
    test_single_write();
    test_stall_write();
    test_held_op();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
